bus_arbiter_rr: RTL

- Round-robin arbiter that shares one memory/peripheral slave port between 2**SELWIDTH requesting masters (e.g. instruction fetch, load/store unit, debug).
- Selects the granted master's request onto the slave port and routes the slave response back only to that master.
- Holds the grant for the whole transaction and aborts a transaction that receives no acknowledge within TIMEOUT cycles.

---
 rtl/bus_arbiter_rr.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one slave port among 2**SELWIDTH masters.
// The grant is held for a whole transaction and aborted on an acknowledge timeout.
module bus_arbiter_rr #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int SELWIDTH  = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2**SELWIDTH-1:0]            m_req,
  input  logic [2**SELWIDTH-1:0]            m_we,
  input  logic [ADDRWIDTH*2**SELWIDTH-1:0]  m_addr,
  input  logic [DATAWIDTH*2**SELWIDTH-1:0]  m_wdata,
  output logic [2**SELWIDTH-1:0]            m_ack,
  output logic [2**SELWIDTH-1:0]            m_err,
  output logic [DATAWIDTH*2**SELWIDTH-1:0]  m_rdata,
  output logic                              s_req,
  output logic                              s_we,
  output logic [ADDRWIDTH-1:0]              s_addr,
  output logic [DATAWIDTH-1:0]              s_wdata,
  input  logic                              s_ack,
  input  logic [DATAWIDTH-1:0]              s_rdata,
  output logic                              grant_valid,
  output logic [SELWIDTH-1:0]               grant_idx
);

  localparam int N  = 2**SELWIDTH;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg, state_next;
  logic [SELWIDTH-1:0] last_grant_reg, last_grant_next;
  logic [SELWIDTH-1:0] grant_idx_reg, grant_idx_next;
  logic [CW-1:0]       count_reg, count_next;

  logic [SELWIDTH-1:0] pick;
  logic [SELWIDTH-1:0] cand;
  logic                pick_found;
  logic                busy;
  logic                timeout_hit;
  logic                fin_ack;
  logic                fin_err;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand = last_grant_reg + SELWIDTH'(k);
      if (m_req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while rst is high, even if BUSY is still registered.
  assign busy        = (state_reg == BUSY) && !rst;
  assign timeout_hit = (TIMEOUT != 0) && (count_reg == LAST_CNT);
  assign fin_ack     = busy && s_ack;
  assign fin_err     = busy && !s_ack && timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= '1;
      grant_idx_reg  <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_idx_reg  <= grant_idx_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_idx_next  = grant_idx_reg;
    count_next      = count_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_idx_next = pick;
          count_next     = '0;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (s_ack || timeout_hit) begin
          last_grant_next = grant_idx_reg;
          state_next      = IDLE;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_req       = busy;
    s_we        = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    grant_valid = busy;
    grant_idx   = rst ? '0 : grant_idx_reg;
    if (busy) begin
      s_we    = m_we[grant_idx_reg];
      s_addr  = m_addr[ADDRWIDTH*grant_idx_reg +: ADDRWIDTH];
      s_wdata = m_wdata[DATAWIDTH*grant_idx_reg +: DATAWIDTH];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_resp
    assign m_ack[gi] = fin_ack && (grant_idx_reg == SELWIDTH'(gi));
    assign m_err[gi] = fin_err && (grant_idx_reg == SELWIDTH'(gi));
    assign m_rdata[DATAWIDTH*gi +: DATAWIDTH] = m_ack[gi] ? s_rdata : '0;
  end

endmodule
